// File: rtl/exe_pkg.sv
// ============================================================================
// Module   : exe_pkg
// Brief    : ALU opcodes and forward-select codes for the execute stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package exe_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

`default_nettype wire

// File: rtl/exe_alu.sv
// ============================================================================
// Module   : exe_alu
// Brief    : Combinational ALU; arithmetic wraps modulo 2^DATA_W.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exe_alu
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result
);

  localparam int c_SH_W = $clog2(DATA_W);

  logic [c_SH_W-1:0] w_shamt;
  assign w_shamt = b[c_SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << w_shamt;
      ALU_SRL:  result = a >> w_shamt;
      ALU_SRA:  result = $signed(a) >>> w_shamt;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_NOR:  result = ~(a | b);
      default:  result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================================
// Module   : exe_stage
// Brief    : Execute stage: operand forwarding, ALU, EXE/MEM register.
//            Optional bubble insertion via flush_EXE when EXE_FLUSH_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exe_stage
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 15,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef EXE_FLUSH_EN
  input  logic              flush_EXE,
`endif
  input  logic [DATA_W-1:0] read_data1_ID_EXE,
  input  logic [DATA_W-1:0] read_data2_ID_EXE,
  input  logic [DATA_W-1:0] immediate_ID_EXE,
  input  logic              ALUSrc_ID_EXE,
  input  logic [3:0]        ALUOp_ID_EXE,
  input  logic [3:0]        MemRead_ID_EXE,
  input  logic [3:0]        MemWrite_ID_EXE,
  input  logic [1:0]        MemtoReg_ID_EXE,
  input  logic              RegWrite_ID_EXE,
  input  logic [REG_W-1:0]  rd_ID_EXE,
  input  logic [PC_W-1:0]   pc_ID_EXE,
  input  logic [1:0]        ForwardA_FRWD,
  input  logic [1:0]        ForwardB_FRWD,
  input  logic [DATA_W-1:0] ALU_Result_MEM_WB,
  input  logic [DATA_W-1:0] ALU_Result_EX_MEM,
  output logic [3:0]        MemRead_EXE_MEM,
  output logic [3:0]        MemWrite_EXE_MEM,
  output logic [1:0]        MemtoReg_EXE_MEM,
  output logic              RegWrite_EXE_MEM,
  output logic [REG_W-1:0]  rd_EXE_MEM,
  output logic [PC_W-1:0]   pc_EXE_MEM,
  output logic [DATA_W-1:0] ALU_Result_EXE_MEM,
  output logic [DATA_W-1:0] write_data_EXE_MEM
);

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_bubble;

`ifdef EXE_FLUSH_EN
  assign w_bubble = flush_EXE;
`else
  assign w_bubble = 1'b0;
`endif

  // Code 2'b11 is reserved and falls back to the register-file value.
  always_comb begin
    w_op_a = read_data1_ID_EXE;
    case (ForwardA_FRWD)
      FWD_MEMWB: w_op_a = ALU_Result_MEM_WB;
      FWD_EXMEM: w_op_a = ALU_Result_EX_MEM;
      default:   w_op_a = read_data1_ID_EXE;
    endcase
  end

  always_comb begin
    w_fwd_b = read_data2_ID_EXE;
    case (ForwardB_FRWD)
      FWD_MEMWB: w_fwd_b = ALU_Result_MEM_WB;
      FWD_EXMEM: w_fwd_b = ALU_Result_EX_MEM;
      default:   w_fwd_b = read_data2_ID_EXE;
    endcase
  end

  assign w_op_b = ALUSrc_ID_EXE ? immediate_ID_EXE : w_fwd_b;

  exe_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (w_op_a),
    .b      (w_op_b),
    .op     (ALUOp_ID_EXE),
    .result (w_alu_result)
  );

  logic [3:0]        r_mem_read;
  logic [3:0]        r_mem_write;
  logic [1:0]        r_mem_to_reg;
  logic              r_reg_write;
  logic [REG_W-1:0]  r_rd;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_write_data;

  // Store data is always the forwarded rs2 value, never the immediate.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_read   <= '0;
      r_mem_write  <= '0;
      r_mem_to_reg <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_pc         <= '0;
      r_alu_result <= '0;
      r_write_data <= '0;
    end else begin
      r_pc         <= pc_ID_EXE;
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      if (w_bubble) begin
        r_mem_read   <= '0;
        r_mem_write  <= '0;
        r_mem_to_reg <= '0;
        r_reg_write  <= 1'b0;
        r_rd         <= '0;
      end else begin
        r_mem_read   <= MemRead_ID_EXE;
        r_mem_write  <= MemWrite_ID_EXE;
        r_mem_to_reg <= MemtoReg_ID_EXE;
        r_reg_write  <= RegWrite_ID_EXE;
        r_rd         <= rd_ID_EXE;
      end
    end
  end

  assign MemRead_EXE_MEM    = r_mem_read;
  assign MemWrite_EXE_MEM   = r_mem_write;
  assign MemtoReg_EXE_MEM   = r_mem_to_reg;
  assign RegWrite_EXE_MEM   = r_reg_write;
  assign rd_EXE_MEM         = r_rd;
  assign pc_EXE_MEM         = r_pc;
  assign ALU_Result_EXE_MEM = r_alu_result;
  assign write_data_EXE_MEM = r_write_data;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// ============================================================================
// Module   : tb_exe_stage
// Brief    : Table-driven self-checking bench for exe_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exe_stage;

  typedef struct {
    logic [31:0] rd1, rd2, imm, memwb, exmem;
    logic        alusrc;
    logic [3:0]  op;
    logic [1:0]  fa, fb;
    logic [3:0]  mread, mwrite;
    logic [1:0]  m2r;
    logic        regw;
    logic [4:0]  rd;
    logic [14:0] pc;
    logic [31:0] exp_res, exp_wd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rd1, rd2, imm, memwb, exmem;
  logic        alusrc;
  logic [3:0]  op;
  logic [1:0]  fa, fb;
  logic [3:0]  mread, mwrite;
  logic [1:0]  m2r;
  logic        regw;
  logic [4:0]  rd;
  logic [14:0] pc;
  logic        flush;

  logic [3:0]  o_mread, o_mwrite;
  logic [1:0]  o_m2r;
  logic        o_regw;
  logic [4:0]  o_rd;
  logic [14:0] o_pc;
  logic [31:0] o_res, o_wd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_stage #(.DATA_W(32), .PC_W(15), .REG_W(5)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
`ifdef EXE_FLUSH_EN
    .flush_EXE          (flush),
`endif
    .read_data1_ID_EXE  (rd1),
    .read_data2_ID_EXE  (rd2),
    .immediate_ID_EXE   (imm),
    .ALUSrc_ID_EXE      (alusrc),
    .ALUOp_ID_EXE       (op),
    .MemRead_ID_EXE     (mread),
    .MemWrite_ID_EXE    (mwrite),
    .MemtoReg_ID_EXE    (m2r),
    .RegWrite_ID_EXE    (regw),
    .rd_ID_EXE          (rd),
    .pc_ID_EXE          (pc),
    .ForwardA_FRWD      (fa),
    .ForwardB_FRWD      (fb),
    .ALU_Result_MEM_WB  (memwb),
    .ALU_Result_EX_MEM  (exmem),
    .MemRead_EXE_MEM    (o_mread),
    .MemWrite_EXE_MEM   (o_mwrite),
    .MemtoReg_EXE_MEM   (o_m2r),
    .RegWrite_EXE_MEM   (o_regw),
    .rd_EXE_MEM         (o_rd),
    .pc_EXE_MEM         (o_pc),
    .ALU_Result_EXE_MEM (o_res),
    .write_data_EXE_MEM (o_wd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] r1, r2, im, mw, em,
                              input logic as, input logic [3:0] o,
                              input logic [1:0] a, b,
                              input logic [3:0] mr, mwr, input logic [1:0] m2,
                              input logic rw, input logic [4:0] d, input logic [14:0] p,
                              input logic [31:0] er, ew);
    vec_t v;
    v.rd1 = r1; v.rd2 = r2; v.imm = im; v.memwb = mw; v.exmem = em;
    v.alusrc = as; v.op = o; v.fa = a; v.fb = b;
    v.mread = mr; v.mwrite = mwr; v.m2r = m2; v.regw = rw; v.rd = d; v.pc = p;
    v.exp_res = er; v.exp_wd = ew;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rd1 = v.rd1; rd2 = v.rd2; imm = v.imm; memwb = v.memwb; exmem = v.exmem;
    alusrc = v.alusrc; op = v.op; fa = v.fa; fb = v.fb;
    mread = v.mread; mwrite = v.mwrite; m2r = v.m2r; regw = v.regw;
    rd = v.rd; pc = v.pc;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".res"},    o_res,            v.exp_res);
    check({tag, ".wdata"},  o_wd,             v.exp_wd);
    check({tag, ".mread"},  {28'd0, o_mread}, {28'd0, v.mread});
    check({tag, ".mwrite"}, {28'd0, o_mwrite},{28'd0, v.mwrite});
    check({tag, ".m2r"},    {30'd0, o_m2r},   {30'd0, v.m2r});
    check({tag, ".regw"},   {31'd0, o_regw},  {31'd0, v.regw});
    check({tag, ".rd"},     {27'd0, o_rd},    {27'd0, v.rd});
    check({tag, ".pc"},     {17'd0, o_pc},    {17'd0, v.pc});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".res"},    o_res,            32'd0);
    check({tag, ".wdata"},  o_wd,             32'd0);
    check({tag, ".ctrl"},   {18'd0, o_mread, o_mwrite, o_m2r, o_regw}, 32'd0);
    check({tag, ".rd_pc"},  {12'd0, o_rd, o_pc}, 32'd0);
  endtask

  vec_t vecs[16];
  vec_t noisy;

  initial begin
    //            rd1          rd2          imm          memwb        exmem        as   op      fa     fb     mr     mw     m2r    rw    rd     pc         exp_res      exp_wd
    vecs[0]  = mk(32'h5,       32'h6,       32'h0,       32'h45,      32'h52,      0, 4'b0010, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 0, 5'd1,  15'h0010, 32'hB,        32'h6);
    vecs[1]  = mk(32'h5,       32'h6,       32'h0,       32'h45,      32'h52,      0, 4'b0010, 2'b01, 2'b00, 4'h0,  4'h0,  2'b00, 0, 5'd2,  15'h0014, 32'h4B,       32'h6);
    vecs[2]  = mk(32'h5,       32'h6,       32'h0,       32'h45,      32'h52,      0, 4'b0010, 2'b01, 2'b10, 4'h0,  4'h0,  2'b00, 0, 5'd3,  15'h0018, 32'h97,       32'h52);
    vecs[3]  = mk(32'h5,       32'h6,       32'h96,      32'h45,      32'h52,      1, 4'b0010, 2'b01, 2'b00, 4'h0,  4'h0,  2'b00, 0, 5'd4,  15'h001C, 32'hDB,       32'h6);
    vecs[4]  = mk(32'h5,       32'h6,       32'h96,      32'h45,      32'h52,      1, 4'b0110, 2'b01, 2'b00, 4'h0,  4'h0,  2'b00, 0, 5'd5,  15'h0020, 32'hFFFFFFAF, 32'h6);
    vecs[5]  = mk(32'hF0F0,    32'hFF00,    32'h0,       32'h0,       32'h0,       0, 4'b0000, 2'b00, 2'b00, 4'hF,  4'h3,  2'b01, 1, 5'd31, 15'h7FFF, 32'hF000,     32'hFF00);
    vecs[6]  = mk(32'h80000000,32'h1,       32'h0,       32'h0,       32'h0,       0, 4'b0111, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 1, 5'd6,  15'h0024, 32'h1,        32'h1);
    vecs[7]  = mk(32'h80000000,32'h1,       32'h0,       32'h0,       32'h0,       0, 4'b1001, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 1, 5'd7,  15'h0028, 32'h0,        32'h1);
    vecs[8]  = mk(32'hF0F0,    32'h0F00,    32'h0,       32'h0,       32'h0,       0, 4'b0001, 2'b00, 2'b00, 4'h1,  4'h0,  2'b10, 1, 5'd8,  15'h002C, 32'hFFF0,     32'h0F00);
    vecs[9]  = mk(32'hFF00,    32'h0FF0,    32'h0,       32'h0,       32'h0,       0, 4'b0011, 2'b00, 2'b00, 4'h0,  4'h8,  2'b11, 0, 5'd9,  15'h0030, 32'hF0F0,     32'h0FF0);
    vecs[10] = mk(32'h1,       32'h7,       32'h24,      32'h0,       32'h0,       1, 4'b0100, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 1, 5'd10, 15'h0034, 32'h10,       32'h7);
    vecs[11] = mk(32'h80000000,32'h4,       32'h0,       32'h0,       32'h0,       0, 4'b0101, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 1, 5'd11, 15'h0038, 32'h08000000, 32'h4);
    vecs[12] = mk(32'h80000000,32'h4,       32'h0,       32'h0,       32'h0,       0, 4'b1000, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 1, 5'd12, 15'h003C, 32'hF8000000, 32'h4);
    vecs[13] = mk(32'hF0F0,    32'h0F00,    32'h0,       32'h0,       32'h0,       0, 4'b1100, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 1, 5'd13, 15'h0040, 32'hFFFF000F, 32'h0F00);
    vecs[14] = mk(32'h12345678,32'h1,       32'h0,       32'h0,       32'h0,       0, 4'b1111, 2'b00, 2'b00, 4'h0,  4'h0,  2'b00, 1, 5'd14, 15'h0044, 32'h0,        32'h1);
    vecs[15] = mk(32'h3,       32'h4,       32'h0,       32'hAAAA,    32'h5555,    0, 4'b0010, 2'b11, 2'b11, 4'h0,  4'h0,  2'b00, 1, 5'd15, 15'h0048, 32'h7,        32'h4);
    noisy    = mk(32'hDEAD,    32'hBEEF,    32'h77,      32'h11,      32'h22,      0, 4'b0010, 2'b01, 2'b10, 4'hF,  4'hF,  2'b11, 1, 5'd21, 15'h1234, 32'h0,        32'h0);

    flush = 1'b0;
    reset_n = 1'b0;
    drive(noisy);

    // Reset held for two edges with live inputs must leave everything clear.
    @(negedge clk);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_zero("reset");

    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted alongside a valid instruction discards it.
    drive(vecs[5]);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_wins");

    // Recovery after reset: the very next instruction lands after one edge.
    reset_n = 1'b1;
    drive(vecs[2]);
    @(posedge clk);
    @(negedge clk);
    check_all("recover", vecs[2]);

    // Outputs hold until the next edge even when inputs change mid-cycle.
    drive(vecs[9]);
    #2;
    check("hold.res", o_res, vecs[2].exp_res);
    @(posedge clk);
    @(negedge clk);
    check_all("after_hold", vecs[9]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipelined 32-bit core, sitting between the ID/EXE and EXE/MEM pipeline registers.
- Selects forwarded operands and, for operand B, the sign-extended immediate.
- Performs the ALU operation.
- Registers the ALU result, store data and the downstream control bundle into the EXE/MEM register on each clk rising edge.

Parameters:
- DATA_W, 32, datapath width.
- PC_W, 15, program-counter width carried down the pipe.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- read_data1_ID_EXE  in  DATA_W  register-file operand A.
- read_data2_ID_EXE  in  DATA_W  register-file operand B.
- immediate_ID_EXE  in  DATA_W  sign-extended immediate.
- ALUSrc_ID_EXE  in  1  1 = ALU B from immediate.
- ALUOp_ID_EXE  in  4  ALU operation code.
- MemRead_ID_EXE  in  4  load byte-enables, passed through.
- MemWrite_ID_EXE  in  4  store byte-enables, passed through.
- MemtoReg_ID_EXE  in  2  writeback select, passed through.
- RegWrite_ID_EXE  in  1  writeback enable, passed through.
- rd_ID_EXE  in  REG_W  destination register.
- pc_ID_EXE  in  PC_W  instruction PC.
- ForwardA_FRWD  in  2  operand A forward select.
- ForwardB_FRWD  in  2  operand B forward select.
- ALU_Result_MEM_WB  in  DATA_W  value forwarded from the MEM/WB register.
- ALU_Result_EX_MEM  in  DATA_W  value forwarded from the EX/MEM register.
- MemRead_EXE_MEM  out  4  registered.
- MemWrite_EXE_MEM  out  4  registered.
- MemtoReg_EXE_MEM  out  2  registered.
- RegWrite_EXE_MEM  out  1  registered.
- rd_EXE_MEM  out  REG_W  registered.
- pc_EXE_MEM  out  PC_W  registered.
- ALU_Result_EXE_MEM  out  DATA_W  registered ALU result.
- write_data_EXE_MEM  out  DATA_W  registered store data.

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low: reset_n sampled low at a rising edge of clk clears every output to 0. Reset has no asynchronous effect.
- Forward mux, applied to A and B independently:
  - 00 = register-file value.
  - 01 = ALU_Result_MEM_WB.
  - 10 = ALU_Result_EX_MEM.
  - 11 = register-file value (reserved).
- opA = forwarded A.
- fwdB = forwarded B.
- opB = ALUSrc_ID_EXE ? immediate_ID_EXE : fwdB.
- ALU is combinational; all arithmetic is modulo 2^32 with no overflow trap. ALUOp encodings:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0011 XOR.
  - 0100 SLL, by opB[4:0].
  - 0101 SRL.
  - 1000 SRA.
  - 0110 SUB (opA-opB).
  - 0111 SLT, signed, result 1/0.
  - 1001 SLTU.
  - 1100 NOR.
  - Any other code → result 0.
- Latency: exactly one cycle. Inputs present before edge N appear on the outputs after edge N. There is no stall input; the register updates every cycle.
- write_data_EXE_MEM = fwdB. Store data is always the forwarded rs2 value and never the immediate.
- All control, rd and pc inputs pass unchanged to their EXE_MEM outputs in the same cycle as the result.
- If reset_n is low together with valid inputs, reset wins and outputs are 0.
- Reset mid-operation discards the in-flight instruction.

Optional Feature:
- Macro EXE_FLUSH_EN.
- When defined: adds input flush_EXE (1 bit). flush_EXE high at an edge (with reset_n high) loads a bubble:
  - RegWrite, MemRead, MemWrite and MemtoReg become 0.
  - rd becomes 0.
  - ALU_Result, write_data and pc still load normally.
- When undefined: no port is added, and the stage behaves as above.

Decomposition:
- Package exe_pkg holds:
  - ALUOp localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR).
  - Forward-select localparams (FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10).
- One sub-module, exe_alu: combinational inputs a, b, op; output result.
- The forward muxes and the EXE/MEM register stay in exe_stage.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with arbitrary inputs → all outputs 0.
- Base add: reset_n=1, rd1=0x5, rd2=0x6, ALUOp=0010, forwards 00, ALUSrc=0 → ALU_Result=0xB, write_data=0x6 after one edge.
- Forward A: ForwardA=01, MEM_WB=0x45, EX_MEM=0x52 → ALU_Result=0x4B.
- Forward B: additionally ForwardB=10 → ALU_Result=0x97, write_data=0x52.
- Immediate and SUB:
  - ALUSrc=1, imm=0x96, ForwardB=00 → ALU_Result=0xDB, write_data=0x6.
  - Then ALUOp=0110 → 0xFFFFFFAF.
- Passthrough and boundary:
  - MemRead=1111, MemWrite=0011, MemtoReg=01, RegWrite=1, rd=31, pc=0x7FFF → identical values one cycle later.
  - SLT with opA=0x80000000, opB=1 → 1.
  - SLTU with the same operands → 0.
